multicycle_control: RTL and testbench

Multicycle control FSM for the 16-bit processor. It sequences fetch, decode, execute, memory and writeback phases. It drives pcwrite/irwrite toward the fetch stage and produces the ALU, memory and register-file control strobes. Opcode comes from ir[15:12]; branch outcome comes from the ALU zero/pos flags. The block also counts retired instructions.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 136 +++++++++++++
 tb/tb_multicycle_control.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multicycle controller and the datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_control_if #(
  parameter int OPW  = 4,
  parameter int CNTW = 16
);
  logic [OPW-1:0]  opcode;
  logic            zero;
  logic            pos;
  logic            mem_ready;
  logic            pcwrite;
  logic            irwrite;
  logic            memread;
  logic            memwrite;
  logic            iord;
  logic            regwrite;
  logic            memtoreg;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic [1:0]      aluop;
  logic [1:0]      pcsource;
  logic [3:0]      state;
  logic            halted;
  logic            illegal;
  logic [CNTW-1:0] retired;

  modport master (
    input  opcode, zero, pos, mem_ready,
    output pcwrite, irwrite, memread, memwrite, iord, regwrite, memtoreg,
           alusrca, alusrcb, aluop, pcsource, state, halted, illegal, retired
  );
  modport slave (
    output opcode, zero, pos, mem_ready,
    input  pcwrite, irwrite, memread, memwrite, iord, regwrite, memtoreg,
           alusrca, alusrcb, aluop, pcsource, state, halted, illegal, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle FSM: fetch/decode/execute/memory/writeback sequencing for the
// 16-bit core, plus a retired-instruction counter and illegal-opcode pulse.
module multicycle_control #(
  parameter int OPW  = 4,
  parameter int CNTW = 16
) (
  input  logic clk,
  input  logic rst,
  multicycle_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9,
    HALT = 4'd10, IMMEX = 4'd11, IMMWB = 4'd12
  } state_t;

  localparam logic [OPW-1:0] OP_R    = OPW'(0);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(1);
  localparam logic [OPW-1:0] OP_LW   = OPW'(2);
  localparam logic [OPW-1:0] OP_SW   = OPW'(3);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(4);
  localparam logic [OPW-1:0] OP_BGT  = OPW'(5);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(6);
  localparam logic [OPW-1:0] OP_HALT = OPW'(15);

  state_t          state_q, state_n;
  logic [CNTW-1:0] retired_q;
  logic            illegal_q;
  logic            retire, ill_op;

  always_comb begin
    state_n = FETCH;
    retire  = 1'b0;
    ill_op  = 1'b0;
    case (state_q)
      FETCH:   state_n = bus.mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (bus.opcode)
          OP_R:          state_n = EXEC;
          OP_ADDI:       state_n = IMMEX;
          OP_LW, OP_SW:  state_n = MEMADDR;
          OP_BEQ, OP_BGT: state_n = BRANCH;
          OP_JMP:        state_n = JUMP;
          OP_HALT: begin state_n = HALT; retire = 1'b1; end
          default:       ill_op = 1'b1;
        endcase
      end
      MEMADDR: state_n = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   state_n = bus.mem_ready ? MEMWB : MEMRD;
      MEMWR: begin
        if (bus.mem_ready) retire = 1'b1;
        else               state_n = MEMWR;
      end
      EXEC:    state_n = RWB;
      IMMEX:   state_n = IMMWB;
      MEMWB, RWB, IMMWB, BRANCH, JUMP: retire = 1'b1;
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // Strobes and selects are purely state-decoded; reset masks them all.
  always_comb begin
    bus.pcwrite  = 1'b0;
    bus.irwrite  = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.iord     = 1'b0;
    bus.regwrite = 1'b0;
    bus.memtoreg = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.aluop    = 2'b00;
    bus.pcsource = 2'b00;
    if (rst) begin
      case (state_q)
        FETCH: begin
          bus.memread = 1'b1;
          bus.alusrcb = 2'b01;
          bus.pcwrite = bus.mem_ready;
          bus.irwrite = bus.mem_ready;
        end
        DECODE:  bus.alusrcb = 2'b10;
        MEMADDR, IMMEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        MEMRD: begin
          bus.memread = 1'b1;
          bus.iord    = 1'b1;
        end
        MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        MEMWR: begin
          bus.memwrite = 1'b1;
          bus.iord     = 1'b1;
        end
        EXEC: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 2'b10;
        end
        RWB, IMMWB: bus.regwrite = 1'b1;
        BRANCH: begin
          bus.alusrca  = 1'b1;
          bus.aluop    = 2'b01;
          bus.pcsource = 2'b01;
          bus.pcwrite  = (bus.opcode == OP_BEQ) ? bus.zero : bus.pos;
        end
        JUMP: begin
          bus.pcwrite  = 1'b1;
          bus.pcsource = 2'b10;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      illegal_q <= ill_op;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign bus.state   = state_q;
  assign bus.halted  = (state_q == HALT);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: an instruction-level path model pushes one expected
// output record per cycle; a negedge monitor pops and compares.
module tb_multicycle_control;
  localparam int CW = 4;  // narrow counter so wrap-around is reachable

  logic clk, rst;
  multicycle_control_if #(.OPW(4), .CNTW(CW)) bus ();
  multicycle_control #(.OPW(4), .CNTW(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit            chk;
    logic [3:0]    st;
    logic [13:0]   ctl;
    logic          hlt;
    logic          ill;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          q[$];
  int            compared = 0, mismatched = 0;
  logic [CW-1:0] cnt = '0;
  bit            ill_pend = 1'b0;

  // {pcwrite,irwrite,memread,memwrite,iord,regwrite,memtoreg,alusrca,alusrcb,aluop,pcsource}
  function automatic logic [13:0] exp_ctl(int st, bit mr, bit z, bit p, logic [3:0] op, bit r);
    logic pcw, irw, mrd, mwr, iord, rw, m2r, asa;
    logic [1:0] asb, aop, pcs;
    {pcw, irw, mrd, mwr, iord, rw, m2r, asa} = '0;
    {asb, aop, pcs} = '0;
    if (r) begin
      case (st)
        0:  begin mrd = 1; asb = 2'b01; pcw = mr; irw = mr; end
        1:  asb = 2'b10;
        2:  begin asa = 1; asb = 2'b10; end
        3:  begin mrd = 1; iord = 1; end
        4:  begin rw = 1; m2r = 1; end
        5:  begin mwr = 1; iord = 1; end
        6:  begin asa = 1; aop = 2'b10; end
        7:  rw = 1;
        8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; pcw = (op == 4'd4) ? z : p; end
        9:  begin pcw = 1; pcs = 2'b10; end
        11: begin asa = 1; asb = 2'b10; end
        12: rw = 1;
        default: ;
      endcase
    end
    return {pcw, irw, mrd, mwr, iord, rw, m2r, asa, asb, aop, pcs};
  endfunction

  // One clock of stimulus: st is the state the model says the DUT is in now.
  task automatic cyc(input int st, input bit mr, input bit r, input bit ret,
                     input bit ill, input bit chk);
    exp_t e;
    rst = r;
    bus.mem_ready = mr;
    bus.zero = 1'($urandom);
    bus.pos  = 1'($urandom);
    e.chk = chk;
    e.st  = 4'(st);
    e.ctl = exp_ctl(st, mr, bus.zero, bus.pos, bus.opcode, r);
    e.hlt = (st == 10);
    e.ill = ill_pend;
    e.ret = cnt;
    q.push_back(e);
    @(posedge clk); #1;
    if (!r) begin
      cnt = '0;
      ill_pend = 1'b0;
    end else begin
      if (ret) cnt = cnt + 1'b1;
      ill_pend = ill;
    end
  endtask

  task automatic do_reset(input int n, input int cur_st, input bit known);
    cyc(cur_st, 1'b1, 1'b0, 1'b0, 1'b0, known);
    for (int i = 1; i < n; i++) cyc(0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Path of states each opcode walks through, with chosen stall counts.
  task automatic run_instr(input logic [3:0] op, input int fs, input int ms);
    bit is_ill;
    is_ill = (op >= 4'd7) && (op <= 4'd14);
    bus.opcode = 4'($urandom);
    for (int i = 0; i < fs; i++) cyc(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    bus.opcode = op;
    cyc(1, 1'($urandom), 1'b1, op == 4'd15, is_ill, 1'b1);
    case (op)
      4'd0: begin cyc(6, 1'($urandom), 1, 0, 0, 1); cyc(7, 1'($urandom), 1, 1, 0, 1); end
      4'd1: begin cyc(11, 1'($urandom), 1, 0, 0, 1); cyc(12, 1'($urandom), 1, 1, 0, 1); end
      4'd2: begin
        cyc(2, 1'($urandom), 1, 0, 0, 1);
        for (int i = 0; i < ms; i++) cyc(3, 1'b0, 1, 0, 0, 1);
        cyc(3, 1'b1, 1, 0, 0, 1);
        cyc(4, 1'($urandom), 1, 1, 0, 1);
      end
      4'd3: begin
        cyc(2, 1'($urandom), 1, 0, 0, 1);
        for (int i = 0; i < ms; i++) cyc(5, 1'b0, 1, 0, 0, 1);
        cyc(5, 1'b1, 1, 1, 0, 1);
      end
      4'd4, 4'd5: cyc(8, 1'($urandom), 1, 1, 0, 1);
      4'd6: cyc(9, 1'($urandom), 1, 1, 0, 1);
      4'd15: for (int i = 0; i < 3; i++) cyc(10, 1'($urandom), 1, 0, 0, 1);
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [13:0] act;
      e = q.pop_front();
      act = {bus.pcwrite, bus.irwrite, bus.memread, bus.memwrite, bus.iord, bus.regwrite,
             bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsource};
      compared++;
      if (act !== e.ctl || (e.chk && (bus.state !== e.st || bus.halted !== e.hlt ||
          bus.illegal !== e.ill || bus.retired !== e.ret))) begin
        mismatched++;
        $display("FAIL cycle_check t=%0t: state %0d want %0d, ctl %b want %b, halted %b want %b, illegal %b want %b, retired %0d want %0d",
                 $time, bus.state, e.st, act, e.ctl, bus.halted, e.hlt, bus.illegal, e.ill,
                 bus.retired, e.ret);
      end
    end
  end

  initial begin
    logic [3:0] op;
    rst = 1'b0;
    bus.opcode = '0;
    bus.zero = 1'b0;
    bus.pos = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    do_reset(3, 0, 1'b0);
    run_instr(4'd2, 4, 2);                        // fetch wait + LW with stalls
    for (int k = 0; k <= 6; k++) run_instr(4'(k), $urandom_range(0, 2), $urandom_range(0, 3));
    run_instr(4'd9, 0, 0);                        // illegal
    for (int k = 0; k < 12; k++) run_instr(4'($urandom_range(0, 6)), 0, 1);  // counter wraps
    run_instr(4'd15, 1, 0);
    do_reset(2, 10, 1'b1);
    // reset while SW is stalled in MEMWR
    run_instr(4'd0, 0, 0);
    bus.opcode = 4'd3;
    cyc(0, 1'b1, 1, 0, 0, 1);
    cyc(1, 1'b0, 1, 0, 0, 1);
    cyc(2, 1'b0, 1, 0, 0, 1);
    cyc(5, 1'b0, 1, 0, 0, 1);
    cyc(5, 1'b0, 1, 0, 0, 1);
    do_reset(2, 5, 1'b1);
    for (int k = 0; k < 400; k++) begin
      op = 4'($urandom_range(0, 15));
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      if (op == 4'd15) do_reset($urandom_range(1, 3), 10, 1'b1);
    end
    repeat (3) @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d records left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
